// File: rtl/sipo_ctrl_pkg.sv
// Shared types and default geometry for the SIPO capture sequencer.
// Bit order of the captured word is selected by SIPO_CTRL_LSB_FIRST_EN (see sipo_shift_reg).
package sipo_ctrl_pkg;

  localparam int SIPO_WIDTH = 4;
  localparam int SIPO_DIV_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sipo_capture_ctrl_if.sv
// Parallel-word valid/ready handshake between the capture sequencer and its consumer.
// Bit order on out_data depends on SIPO_CTRL_LSB_FIRST_EN in the producer.
interface sipo_capture_ctrl_if
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
);

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// Serial-to-parallel shift datapath with synchronous clear and a look-ahead of the next word.
// SIPO_CTRL_LSB_FIRST_EN defined: bits enter at the top and shift right; otherwise at bit 0, shifting left.
module sipo_shift_reg
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_shift
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // q_shift is the register contents including this cycle's bit, so the
  // controller can hand off a completed word on the same edge it is sampled.
`ifdef SIPO_CTRL_LSB_FIRST_EN
  assign q_shift = {serial_in, shift_q[WIDTH-1:1]};
`else
  assign q_shift = {shift_q[WIDTH-2:0], serial_in};
`endif

  always_comb begin
    shift_d = shift_q;
    if (clr) begin
      shift_d = '0;
    end else if (shift_en) begin
      shift_d = q_shift;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q = shift_q;

endmodule

// File: rtl/sipo_capture_ctrl.sv
// Programmable-rate SIPO capture sequencer: prescaled shift strobe, bit counting and word handoff.
// Bit order is selected by SIPO_CTRL_LSB_FIRST_EN (undefined: MSB-first).
module sipo_capture_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH,
  parameter int DIV_W = SIPO_DIV_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [DIV_W-1:0]            div,
  input  logic                        serial_in,
  input  logic                        clr_ovr,
  output logic                        sample_en,
  output logic                        busy,
  output logic                        overrun,
  sipo_capture_ctrl_if.master         out_if
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q,   state_d;
  logic [DIV_W-1:0]   div_q,     div_d;
  logic [DIV_W-1:0]   presc_q,   presc_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q,   overrun_d;

  logic               start_acc;
  logic               stop_run;
  logic               sample_now;
  logic               word_done;
  logic               word_load;
  logic               word_drop;
  logic               shift_clr;
  logic [WIDTH-1:0]   shift_word;
  logic [WIDTH-1:0]   word_next;

  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (shift_clr),
    .shift_en  (sample_now),
    .serial_in (serial_in),
    .q         (shift_word),
    .q_shift   (word_next)
  );

  // Control decode; stop outranks start and also suppresses the strobe.
  always_comb begin
    start_acc  = (state_q == IDLE) && start && !stop;
    stop_run   = (state_q == RUN) && stop;
    sample_now = (state_q == RUN) && (presc_q == div_q) && !stop;
    word_done  = sample_now && (bit_cnt_q == LAST_BIT);
    word_load  = word_done && (!out_valid_q || out_if.out_ready);
    word_drop  = word_done && !word_load;
    shift_clr  = start_acc || stop_run;
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    presc_d   = presc_q;
    bit_cnt_d = bit_cnt_q;
    if (start_acc) begin
      state_d   = RUN;
      div_d     = div;
      presc_d   = '0;
      bit_cnt_d = '0;
    end else if (stop_run) begin
      state_d   = IDLE;
      presc_d   = '0;
      bit_cnt_d = '0;
    end else if (state_q == RUN) begin
      if (sample_now) begin
        presc_d   = '0;
        bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
      end else begin
        presc_d   = presc_q + 1'b1;
      end
    end
  end

  // Output holding register: a fresh word may replace one being consumed this cycle.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (word_load) begin
      out_data_d  = word_next;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_if.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (word_drop) begin
      overrun_d = 1'b1;
    end else if (clr_ovr || start_acc) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      presc_q     <= '0;
      bit_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      presc_q     <= presc_d;
      bit_cnt_q   <= bit_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sample_en        = sample_now;
  assign busy             = (state_q == RUN);
  assign overrun          = overrun_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule
